// File: rtl/regfile_pkg.sv
// Shared register-file constants, types and the address-to-enable decoder.
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // One-hot decode of a register address into a write-enable vector.
  function automatic logic [NREG-1:0] onehot(input reg_addr_t a);
    onehot    = '0;
    onehot[a] = 1'b1;
  endfunction
endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a tie goes to the port that did not win last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       hold,
  input  logic [1:0] xfer,
  output logic [1:0] gnt
);
  logic last_grant;

  // Grant selection; nothing is granted while the register file is held.
  always_comb begin
    gnt = 2'b00;
    if (!hold) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Remember the most recent winner; reset favours port 0 on the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          last_grant <= 1'b1;
    else if (xfer[0]) last_grant <= 1'b0;
    else if (xfer[1]) last_grant <= 1'b1;
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter for two writeback sources.
// Optional pending-write scoreboard enabled by defining REGWR_SCOREBOARD_EN.
module regfile_wr_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int CNT_W  = 16,
  localparam int NREG  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [ADDR_W-1:0] in0_addr,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [ADDR_W-1:0] in1_addr,
  input  logic [DATA_W-1:0] in1_data,
`ifdef REGWR_SCOREBOARD_EN
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic [NREG-1:0]   busy,
`endif
  output logic [NREG-1:0]   wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  conflict_cnt
);
  import regfile_pkg::*;

  logic [1:0]        gnt;
  logic [1:0]        xfer;
  logic              xfer_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   sel_oh;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (reset),
    .req  ({in1_valid, in0_valid}),
    .hold (hold),
    .xfer (xfer),
    .gnt  (gnt)
  );

  assign in0_ready = gnt[0];
  assign in1_ready = gnt[1];
  assign xfer      = gnt & {in1_valid, in0_valid};
  assign xfer_any  = |xfer;
  assign sel_addr  = xfer[1] ? in1_addr : in0_addr;
  assign sel_data  = xfer[1] ? in1_data : in0_data;
  assign sel_oh    = NREG'(onehot(reg_addr_t'(sel_addr)));

  // Write register: r0 is hardwired zero, so its writes are accepted but never enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (xfer_any) begin
      wr_en   <= (sel_addr != '0) ? sel_oh : '0;
      wr_addr <= sel_addr;
      wr_data <= sel_data;
    end else begin
      wr_en   <= '0;
    end
  end

  // Saturating count of cycles in which both sources competed for the port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      conflict_cnt <= '0;
    else if (in0_valid && in1_valid && !hold && conflict_cnt != '1)
      conflict_cnt <= conflict_cnt + 1'b1;
  end

`ifdef REGWR_SCOREBOARD_EN
  logic [NREG-1:0] claim_oh;
  logic [NREG-1:0] busy_nxt;

  assign claim_oh = NREG'(onehot(reg_addr_t'(claim_addr)));

  // Pending-write mask: a same-cycle claim overrides the clear (newer producer pending).
  always_comb begin
    busy_nxt = busy & ~(xfer_any ? sel_oh : '0);
    if (claim_valid) busy_nxt = busy_nxt | claim_oh;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end
`endif
endmodule
